seg7_scan_driver: RTL and testbench

- Parametrised successor to the single-digit BCD-to-7-segment decoder.
- Drives a DIGITS-wide common-anode multiplexed display from a packed BCD bus, one digit at a time.
- Includes a programmable refresh prescaler, an anti-ghosting guard interval, per-digit blanking, decimal points and a glitch-free shadow load.
- Sits between the clock counter logic and the board display pins.

---
 rtl/seg7_scan_driver.sv | 188 ++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment scanner: shadow-loaded packed BCD, refresh prescaler,
// anti-ghosting guard interval, per-digit blanking and decimal points. Optional: SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 50000,
  parameter int GUARD          = 2,
  parameter bit ACTIVE_LOW_SEG = 1'b1,
  parameter bit ACTIVE_LOW_AN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digits_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int CNT_MAX = (CLK_DIV > GUARD) ? CLK_DIV : GUARD;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int IW      = $clog2(DIGITS);

  localparam logic [CW-1:0]     GUARD_LAST = CW'(GUARD - 1);
  localparam logic [CW-1:0]     SHOW_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]     CNT_ZERO   = {CW{1'b0}};
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [IW-1:0]     IDX_ZERO   = {IW{1'b0}};
  localparam logic [0:0]        ST_BLANK   = 1'b0;
  localparam logic [0:0]        ST_SHOW    = 1'b1;
  localparam logic [6:0]        SEG_OFF    = ACTIVE_LOW_SEG ? 7'h7f : 7'h00;
  localparam logic              DP_ON      = ACTIVE_LOW_SEG ? 1'b0 : 1'b1;
  localparam logic              DP_OFF     = ACTIVE_LOW_SEG ? 1'b1 : 1'b0;
  localparam logic [DIGITS-1:0] AN_OFF     = ACTIVE_LOW_AN ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [DIGITS-1:0] ONE_HOT0   = {{(DIGITS-1){1'b0}}, 1'b1};

  // Active-low glyph table shared with the original single-digit decoder.
  function automatic logic [6:0] decode_low(input logic [3:0] bcd);
    logic [6:0] s;
    case (bcd)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0011000;
      default: s = 7'b0000110;
    endcase
    return s;
  endfunction

  logic [0:0]          state_r, state_s;
  logic [CW-1:0]       cnt_r, cnt_s;
  logic [IW-1:0]       idx_r, idx_s;
  logic [4*DIGITS-1:0] shadow_digits_r;
  logic [DIGITS-1:0]   shadow_dp_r, shadow_blank_r;
  logic [6:0]          seg_r, seg_s;
  logic                dp_r, dp_s;
  logic [DIGITS-1:0]   an_r, an_s, onehot_s;
  logic                frame_r, frame_s;
  logic [3:0]          digit_sel_s;
  logic                dp_sel_s, blank_sel_s, auto_blank_s, dark_s;

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0]   lz_run_s;
  logic                lz_carry_s;

  // Leading-zero run from the top digit down; a lit dp terminates the run.
  always_comb begin
    lz_carry_s = 1'b1;
    lz_run_s   = {DIGITS{1'b0}};
    for (int j = DIGITS - 1; j >= 0; j--) begin
      lz_run_s[j] = (shadow_digits_r[4*j +: 4] == 4'd0) && !shadow_dp_r[j] && lz_carry_s;
      lz_carry_s  = lz_run_s[j];
    end
    auto_blank_s = (idx_r != IDX_ZERO) && lz_run_s[idx_r];
  end
`else
  assign auto_blank_s = 1'b0;
`endif

  // Scan FSM next-state; the shadow is sampled only on the BLANK->SHOW transition.
  always_comb begin
    digit_sel_s = 4'(shadow_digits_r >> (4 * idx_r));
    dp_sel_s    = shadow_dp_r[idx_r];
    blank_sel_s = shadow_blank_r[idx_r];
    dark_s      = blank_sel_s | auto_blank_s;
    onehot_s    = ONE_HOT0 << idx_r;
    state_s     = state_r;
    cnt_s       = cnt_r;
    idx_s       = idx_r;
    seg_s       = seg_r;
    dp_s        = dp_r;
    an_s        = an_r;
    frame_s     = 1'b0;
    case (state_r)
      ST_BLANK: begin
        if (cnt_r == GUARD_LAST) begin
          state_s = ST_SHOW;
          cnt_s   = CNT_ZERO;
          an_s    = ACTIVE_LOW_AN ? ~onehot_s : onehot_s;
          if (dark_s) begin
            seg_s = SEG_OFF;
            dp_s  = DP_OFF;
          end else begin
            seg_s = ACTIVE_LOW_SEG ? decode_low(digit_sel_s) : ~decode_low(digit_sel_s);
            dp_s  = dp_sel_s ? DP_ON : DP_OFF;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
          an_s  = AN_OFF;
          seg_s = SEG_OFF;
          dp_s  = DP_OFF;
        end
      end
      ST_SHOW: begin
        if (cnt_r == SHOW_LAST) begin
          state_s = ST_BLANK;
          cnt_s   = CNT_ZERO;
          an_s    = AN_OFF;
          seg_s   = SEG_OFF;
          dp_s    = DP_OFF;
          idx_s   = (idx_r == IDX_LAST) ? IDX_ZERO : idx_r + IW'(1);
          frame_s = (idx_r == IDX_LAST);
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = ST_BLANK;
        cnt_s   = CNT_ZERO;
        an_s    = AN_OFF;
        seg_s   = SEG_OFF;
        dp_s    = DP_OFF;
      end
    endcase
  end

  // Scan state and registered display outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_BLANK;
      cnt_r   <= CNT_ZERO;
      idx_r   <= IDX_ZERO;
      seg_r   <= SEG_OFF;
      dp_r    <= DP_OFF;
      an_r    <= AN_OFF;
      frame_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      seg_r   <= seg_s;
      dp_r    <= dp_s;
      an_r    <= an_s;
      frame_r <= frame_s;
    end
  end

  // Shadow registers for the display content.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_digits_r <= {(4*DIGITS){1'b0}};
      shadow_dp_r     <= {DIGITS{1'b0}};
      shadow_blank_r  <= {DIGITS{1'b0}};
    end else if (load) begin
      shadow_digits_r <= digits_in;
      shadow_dp_r     <= dp_in;
      shadow_blank_r  <= blank_in;
    end else begin
      shadow_digits_r <= shadow_digits_r;
      shadow_dp_r     <= shadow_dp_r;
      shadow_blank_r  <= shadow_blank_r;
    end
  end

  assign seg   = seg_r;
  assign dp    = dp_r;
  assign an    = an_r;
  assign frame = frame_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver (DIGITS=4, CLK_DIV=4, GUARD=2) with a slot scoreboard.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0000;
  logic [3:0]  dp_in = 4'b0000;
  logic [3:0]  blank_in = 4'b0000;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frm;
  } slot_t;

  slot_t sb[$];

  seg7_scan_driver #(
    .DIGITS(4), .CLK_DIV(4), .GUARD(2), .ACTIVE_LOW_SEG(1'b1), .ACTIVE_LOW_AN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .dp_in(dp_in),
    .blank_in(blank_in), .seg(seg), .dp(dp), .an(an), .frame(frame)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d, input logic f);
    slot_t e;
    e.an = a; e.seg = s; e.dp = d; e.frm = f;
    sb.push_back(e);
  endtask

  // Consume one lit slot plus its guard gap; optionally load mid-slot or on the next BLANK->SHOW edge.
  task automatic check_slot(input string tag, input bit mid_ld, input bit edge_ld,
                            input logic [15:0] nv, input logic [3:0] ndp, input logic [3:0] nbl);
    slot_t       e;
    logic [11:0] cur;
    int          waitc, lit, off, frm;
    waitc = 0;
    while (an === 4'hF && waitc < 50) begin
      tick();
      waitc++;
    end
    chk({tag, "_wait"}, 32'(waitc < 50), 32'd1);
    chk({tag, "_sb"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) e = sb.pop_front();
    else e = '0;
    chk({tag, "_an"}, 32'(an), 32'(e.an));
    chk({tag, "_seg"}, 32'(seg), 32'(e.seg));
    chk({tag, "_dp"}, 32'(dp), 32'(e.dp));
    cur = {an, seg, dp};
    lit = 0;
    frm = 0;
    if (mid_ld) begin
      digits_in = nv; dp_in = ndp; blank_in = nbl; load = 1'b1;
    end
    while ({an, seg, dp} === cur && lit < 50) begin
      tick();
      load = 1'b0;
      lit++;
      frm += int'(frame);
    end
    chk({tag, "_lit"}, 32'(lit), 32'd4);
    chk({tag, "_gap_an"}, 32'(an), 32'hF);
    off = 0;
    while (an === 4'hF && off < 50) begin
      if (edge_ld && off == 1) begin
        digits_in = nv; dp_in = ndp; blank_in = nbl; load = 1'b1;
      end
      tick();
      load = 1'b0;
      off++;
      frm += int'(frame);
    end
    chk({tag, "_gap"}, 32'(off), 32'd2);
    chk({tag, "_frame"}, 32'(frm), 32'(e.frm));
  endtask

  task automatic slot(input string tag);
    check_slot(tag, 1'b0, 1'b0, 16'h0000, 4'b0000, 4'b0000);
  endtask

  initial begin
    // Reset held for three cycles
    tick(); tick(); tick();
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_frame", 32'(frame), 32'd0);
    rst = 1'b0; load = 1'b1; digits_in = 16'h1234;
    tick();
    load = 1'b0;
    chk("rel_1clk_an", 32'(an), 32'hF);
    tick();
    chk("rel_2clk_an", 32'(an), 32'hE);

    // Frame 1: scan order of 1234; last slot loads FA09 on the BLANK->SHOW edge
    push(4'hE, 7'h19, 1'b1, 1'b0); push(4'hD, 7'h30, 1'b1, 1'b0);
    push(4'hB, 7'h24, 1'b1, 1'b0); push(4'h7, 7'h79, 1'b1, 1'b1);
    slot("f1d0"); slot("f1d1"); slot("f1d2");
    check_slot("f1d3", 1'b0, 1'b1, 16'hFA09, 4'b0000, 4'b0000);

    // Frame 2: digit 0 still shows old 4, then FA09 glyphs
    push(4'hE, 7'h19, 1'b1, 1'b0); push(4'hD, 7'h40, 1'b1, 1'b0);
    push(4'hB, 7'h06, 1'b1, 1'b0); push(4'h7, 7'h06, 1'b1, 1'b1);
    slot("f2d0"); slot("f2d1"); slot("f2d2"); slot("f2d3");

    // Frame 3: mid-slot load of 1234 during digit 0 (shows 9 to slot end)
    push(4'hE, 7'h18, 1'b1, 1'b0);
    check_slot("f3d0", 1'b1, 1'b0, 16'h1234, 4'b0000, 4'b0000);
    push(4'hD, 7'h30, 1'b1, 1'b0); push(4'hB, 7'h24, 1'b1, 1'b0); push(4'h7, 7'h79, 1'b1, 1'b1);
    slot("f3d1"); slot("f3d2"); slot("f3d3");

    // Frame 4: change to 5678 mid digit 1 slot
    push(4'hE, 7'h19, 1'b1, 1'b0);
    slot("f4d0");
    push(4'hD, 7'h30, 1'b1, 1'b0);
    check_slot("f4d1", 1'b1, 1'b0, 16'h5678, 4'b0000, 4'b0000);
    push(4'hB, 7'h02, 1'b1, 1'b0); push(4'h7, 7'h12, 1'b1, 1'b1);
    slot("f4d2"); slot("f4d3");

    // Frame 5: blank digit 2, dp on digit 0 (loaded mid digit 0)
    push(4'hE, 7'h00, 1'b1, 1'b0);
    check_slot("f5d0", 1'b1, 1'b0, 16'h5678, 4'b0001, 4'b0100);
    push(4'hD, 7'h78, 1'b1, 1'b0); push(4'hB, 7'h7F, 1'b1, 1'b0); push(4'h7, 7'h12, 1'b1, 1'b1);
    slot("f5d1"); slot("f5d2"); slot("f5d3");

    // Frame 6: dp lit on digit 0, then reset in the middle of digit 2
    push(4'hE, 7'h00, 1'b0, 1'b0); push(4'hD, 7'h78, 1'b1, 1'b0);
    slot("f6d0"); slot("f6d1");
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rst_an", 32'(an), 32'hF);
    chk("mid_rst_seg", 32'(seg), 32'h7F);
    chk("mid_rst_dp", 32'(dp), 32'd1);
    chk("mid_rst_frame", 32'(frame), 32'd0);
    rst = 1'b0; load = 1'b1; digits_in = 16'h0070; dp_in = 4'b0000; blank_in = 4'b0000;
    tick();
    load = 1'b0;
    chk("rel2_1clk_an", 32'(an), 32'hF);
    tick();
    chk("rel2_2clk_an", 32'(an), 32'hE);

    // Frame 7: 0070 with or without leading-zero suppression
    push(4'hE, 7'h40, 1'b1, 1'b0); push(4'hD, 7'h78, 1'b1, 1'b0);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    push(4'hB, 7'h7F, 1'b1, 1'b0); push(4'h7, 7'h7F, 1'b1, 1'b1);
`else
    push(4'hB, 7'h40, 1'b1, 1'b0); push(4'h7, 7'h40, 1'b1, 1'b1);
`endif
    slot("f7d0"); slot("f7d1"); slot("f7d2"); slot("f7d3");
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
